// File: rtl/priority_decoder_buf_if.sv
// Handshake bundle for priority_decoder_buf: index/None in, one-hot out, status.
// Latency: none; wires only.
// Backpressure: in_ready/out_ready carried here, semantics defined by the buffer.
interface priority_decoder_buf_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
);
    localparam int OUT_W = 1 << IDX_W;

    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx;
    logic             in_none;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_onehot;
    logic             out_none;
    logic [CNT_W-1:0] dec_cnt;
    logic [OUT_W-1:0] acc_mask;

    // Producer/consumer side (drives index stream and consumer ready)
    modport master (
        output in_valid, in_idx, in_none, out_ready,
        input  in_ready, out_valid, out_onehot, out_none, dec_cnt, acc_mask
    );

    // Buffer side
    modport slave (
        input  in_valid, in_idx, in_none, out_ready,
        output in_ready, out_valid, out_onehot, out_none, dec_cnt, acc_mask
    );
endinterface

// File: rtl/priority_decoder_buf.sv
// Decodes index+None to one-hot into a 2-entry skid buffer; counts non-None outputs.
// Latency: 1 cycle from input transfer to out_valid; full throughput (1/cycle).
// Backpressure: in_ready = occupancy<2 from registered state; optional PRIO_DEC_ACCUM_EN adds acc_mask.
module priority_decoder_buf #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    priority_decoder_buf_if.slave bus
);
    localparam int OUT_W = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [OUT_W-1:0] ONE_LSB = {{(OUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic             r_not_full;
    logic [OUT_W-1:0] r_head_onehot;
    logic             r_head_none;
    logic [OUT_W-1:0] r_tail_onehot;
    logic             r_tail_none;
    logic [CNT_W-1:0] r_dec_cnt;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [OUT_W-1:0] w_dec_onehot;

    // Ready comes from registered occupancy only; rst masks it so nothing is
    // accepted while reset is held, and it is already high the cycle after.
    assign w_in_ready   = r_not_full & ~rst;
    assign w_push       = bus.in_valid & w_in_ready;
    assign w_pop        = r_out_valid & bus.out_ready & ~rst;

    // Decode happens at write time so the head register drives the output directly.
    assign w_dec_onehot = bus.in_none ? '0 : (ONE_LSB << bus.in_idx);

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_onehot = r_head_onehot;
    assign bus.out_none   = r_head_none;
    assign bus.dec_cnt    = r_dec_cnt;

    // Occupancy FSM with head/tail storage; head is always the presented entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_EMPTY;
            r_out_valid   <= 1'b0;
            r_not_full    <= 1'b1;
            r_head_onehot <= '0;
            r_head_none   <= 1'b0;
            r_tail_onehot <= '0;
            r_tail_none   <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_head_onehot <= w_dec_onehot;
                        r_head_none   <= bus.in_none;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_push && !w_pop) begin
                        r_tail_onehot <= w_dec_onehot;
                        r_tail_none   <= bus.in_none;
                        r_not_full    <= 1'b0;
                        r_state       <= ST_FULL;
                    end else if (w_pop && !w_push) begin
                        r_out_valid   <= 1'b0;
                        r_state       <= ST_EMPTY;
                    end else if (w_pop && w_push) begin
                        r_head_onehot <= w_dec_onehot;
                        r_head_none   <= bus.in_none;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only a pop can move state
                    if (w_pop) begin
                        r_head_onehot <= r_tail_onehot;
                        r_head_none   <= r_tail_none;
                        r_not_full    <= 1'b1;
                        r_state       <= ST_ONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_not_full  <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of non-None output transfers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_cnt <= '0;
        end else if (w_pop && !r_head_none && (r_dec_cnt != CNT_MAX)) begin
            r_dec_cnt <= r_dec_cnt + 1'b1;
        end
    end

`ifdef PRIO_DEC_ACCUM_EN
    logic [OUT_W-1:0] r_acc_mask;

    // Sticky OR of every line handed to the consumer; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_mask <= '0;
        end else if (w_pop) begin
            r_acc_mask <= r_acc_mask | r_head_onehot;
        end
    end

    assign bus.acc_mask = r_acc_mask;
`else
    assign bus.acc_mask = '0;
`endif

endmodule

// File: tb/tb_priority_decoder_buf.sv
// Directed bench for priority_decoder_buf: reset, decode, None, backpressure,
// saturation, accumulator and mid-burst reset.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_priority_decoder_buf;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    priority_decoder_buf_if #(.IDX_W(3), .CNT_W(8)) bus ();

    priority_decoder_buf #(.IDX_W(3), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_idx = '0; bus.in_none = 1'b0; bus.out_ready = 1'b0;
        cyc();
        cyc();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_during got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_onehot !== 8'h00) begin errors++; $display("FAIL rst_onehot got=%h exp=00", bus.out_onehot); end
        checks++; if (bus.out_none !== 1'b0) begin errors++; $display("FAIL rst_none got=%b exp=0", bus.out_none); end
        checks++; if (bus.dec_cnt !== 8'd0) begin errors++; $display("FAIL rst_dec_cnt got=%0d exp=0", bus.dec_cnt); end
        checks++; if (bus.acc_mask !== 8'h00) begin errors++; $display("FAIL rst_acc_mask got=%h exp=00", bus.acc_mask); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_decode();
        bus.in_valid = 1'b1; bus.in_idx = 3'd5; bus.in_none = 1'b0; bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dec_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_onehot !== 8'b0010_0000) begin errors++; $display("FAIL dec_onehot got=%h exp=20", bus.out_onehot); end
        checks++; if (bus.out_none !== 1'b0) begin errors++; $display("FAIL dec_none got=%b exp=0", bus.out_none); end
        cyc();
        checks++; if (bus.dec_cnt !== 8'd1) begin errors++; $display("FAIL dec_cnt got=%0d exp=1", bus.dec_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dec_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_none();
        bus.in_valid = 1'b1; bus.in_idx = 3'd3; bus.in_none = 1'b1; bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0; bus.in_none = 1'b0;
        checks++; if (bus.out_onehot !== 8'h00) begin errors++; $display("FAIL none_onehot got=%h exp=00", bus.out_onehot); end
        checks++; if (bus.out_none !== 1'b1) begin errors++; $display("FAIL none_flag got=%b exp=1", bus.out_none); end
        cyc();
        checks++; if (bus.dec_cnt !== 8'd1) begin errors++; $display("FAIL none_dec_cnt got=%0d exp=1", bus.dec_cnt); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_none = 1'b0; bus.in_idx = 3'd0;
        cyc();
        bus.in_idx = 3'd1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_one got=%b exp=1", bus.in_ready); end
        cyc();
        bus.in_idx = 3'd2;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_onehot !== 8'h01) begin errors++; $display("FAIL bp_head0 got=%h exp=01", bus.out_onehot); end
        cyc();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_hold got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_onehot !== 8'h01 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_head_stable got=%h/%b exp=01/1", bus.out_onehot, bus.out_valid); end
        bus.out_ready = 1'b1;
        cyc();
        checks++; if (bus.out_onehot !== 8'h02) begin errors++; $display("FAIL bp_head1 got=%h exp=02", bus.out_onehot); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release got=%b exp=1", bus.in_ready); end
        cyc();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_onehot !== 8'h04 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_head2 got=%h/%b exp=04/1", bus.out_onehot, bus.out_valid); end
        cyc();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", bus.out_valid); end
        checks++; if (bus.dec_cnt !== 8'd4) begin errors++; $display("FAIL bp_dec_cnt got=%0d exp=4", bus.dec_cnt); end
    endtask

    task automatic test_saturation();
        logic [7:0] exp_oh;
        int         exp_cnt;
        bus.out_ready = 1'b1; bus.in_none = 1'b0;
        for (int i = 0; i < 300; i++) begin
            bus.in_valid = 1'b1;
            bus.in_idx = 3'(i % 8);
            if (i > 0) begin
                exp_oh  = 8'h01 << ((i - 1) % 8);
                exp_cnt = (3 + i > 255) ? 255 : 3 + i;
                checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL sat_stream i=%0d vld=%b rdy=%b exp=1/1", i, bus.out_valid, bus.in_ready); end
                checks++; if (bus.out_onehot !== exp_oh) begin errors++; $display("FAIL sat_order i=%0d got=%h exp=%h", i, bus.out_onehot, exp_oh); end
                checks++; if (bus.dec_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, bus.dec_cnt, exp_cnt); end
            end
            cyc();
        end
        bus.in_valid = 1'b0;
        cyc();
        checks++; if (bus.dec_cnt !== 8'd255) begin errors++; $display("FAIL sat_final got=%0d exp=255", bus.dec_cnt); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL sat_drain got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_accum();
        logic [7:0] exp_mask;
`ifdef PRIO_DEC_ACCUM_EN
        exp_mask = 8'h81;
`else
        exp_mask = 8'h00;
`endif
        rst = 1'b1; bus.in_valid = 1'b0;
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b1; bus.in_none = 1'b0;
        bus.in_valid = 1'b1; bus.in_idx = 3'd7;
        cyc();
        bus.in_idx = 3'd0;
        cyc();
        bus.in_idx = 3'd7;
        cyc();
        bus.in_valid = 1'b0;
        cyc();
        checks++; if (bus.acc_mask !== exp_mask) begin errors++; $display("FAIL accum_mask got=%h exp=%h", bus.acc_mask, exp_mask); end
        checks++; if (bus.dec_cnt !== 8'd3) begin errors++; $display("FAIL accum_dec_cnt got=%0d exp=3", bus.dec_cnt); end
    endtask

    task automatic test_rst_midburst();
        bus.out_ready = 1'b0; bus.in_none = 1'b0;
        bus.in_valid = 1'b1; bus.in_idx = 3'd1;
        cyc();
        bus.in_idx = 3'd3;
        cyc();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL mid_full got=%b exp=0", bus.in_ready); end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0; bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_empty got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.acc_mask !== 8'h00) begin errors++; $display("FAIL mid_acc_mask got=%h exp=00", bus.acc_mask); end
        checks++; if (bus.dec_cnt !== 8'd0) begin errors++; $display("FAIL mid_dec_cnt got=%0d exp=0", bus.dec_cnt); end
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_idx = 3'd6;
        cyc();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_onehot !== 8'h40 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_fresh got=%h/%b exp=40/1", bus.out_onehot, bus.out_valid); end
        bus.out_ready = 1'b1;
        cyc();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale got=%b exp=0", bus.out_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_idx = '0; bus.in_none = 1'b0; bus.out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_decode();
        test_none();
        test_back_to_back();
        test_saturation();
        test_accum();
        test_rst_midburst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
